// File: rtl/icache_port_arbiter.sv
// Two-requester arbiter (demand fetch, next-line prefetch) in front of a single
// i-cache request/response channel; one transaction outstanding, flush-aware.
module icache_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int LINE_W     = 128,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   dmd_addr_i,
    input  logic              dmd_valid_i,
    output logic              dmd_ready_o,
    input  logic [XLEN-1:0]   pf_addr_i,
    input  logic              pf_valid_i,
    output logic              pf_ready_o,
    output logic [LINE_W-1:0] dmd_data_o,
    output logic              dmd_data_valid_o,
    input  logic              dmd_data_ready_i,
    output logic [LINE_W-1:0] pf_data_o,
    output logic              pf_data_valid_o,
    input  logic              pf_data_ready_i,
    output logic [XLEN-1:0]   addr_o,
    output logic              addr_valid_o,
    input  logic              addr_ready_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DISCARD} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt, starve_d;
    logic              flush_seen_q, flush_seen_d;

    logic              grant_pf;
    logic              dmd_grant, pf_grant;
    logic              owner_rdy;
    logic              fwd_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            owner_q      <= 1'b0;
            starve_cnt   <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            owner_q      <= owner_d;
            starve_cnt   <= starve_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // Prefetch wins when demand is idle or demand has been favoured STARVE_LIM times in a row.
    assign grant_pf  = pf_valid_i && (!dmd_valid_i || (starve_cnt == CNT_W'(STARVE_LIM)));
    assign owner_rdy = owner_q ? pf_data_ready_i : dmd_data_ready_i;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        owner_d      = owner_q;
        starve_d     = starve_cnt;
        flush_seen_d = flush_seen_q;
        dmd_grant    = 1'b0;
        pf_grant     = 1'b0;
        addr_valid_o = 1'b0;
        data_ready_o = 1'b0;
        fwd_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                flush_seen_d = 1'b0;
                if (!flush_i && (dmd_valid_i || pf_valid_i)) begin
                    state_d = ADDR;
                    if (grant_pf) begin
                        pf_grant = 1'b1;
                        owner_d  = 1'b1;
                        addr_d   = pf_addr_i;
                        starve_d = '0;
                    end else begin
                        dmd_grant = 1'b1;
                        owner_d   = 1'b0;
                        addr_d    = dmd_addr_i;
                        if (pf_valid_i)
                            starve_d = starve_cnt + CNT_W'(1);
                    end
                end
            end
            ADDR: begin
                // The address handshake must complete even if a flush arrives; remember it.
                addr_valid_o = 1'b1;
                if (addr_ready_i) begin
                    state_d      = (flush_seen_q || flush_i) ? DISCARD : WAIT;
                    flush_seen_d = 1'b0;
                end else if (flush_i) begin
                    flush_seen_d = 1'b1;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    data_ready_o = 1'b1;
                    state_d      = data_valid_i ? IDLE : DISCARD;
                end else begin
                    data_ready_o = owner_rdy;
                    fwd_valid    = data_valid_i;
                    if (data_valid_i && owner_rdy)
                        state_d = IDLE;
                end
            end
            DISCARD: begin
                data_ready_o = 1'b1;
                if (data_valid_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush_i)
            starve_d = '0;
    end

    // Grants are combinational from valid; hold them low while reset is asserted.
    assign dmd_ready_o      = dmd_grant & rst_n_i;
    assign pf_ready_o       = pf_grant & rst_n_i;

    assign dmd_data_o       = data_i;
    assign pf_data_o        = data_i;
    assign dmd_data_valid_o = fwd_valid & ~owner_q;
    assign pf_data_valid_o  = fwd_valid & owner_q;

    assign addr_o           = addr_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_icache_port_arbiter.sv
// Directed self-checking bench for icache_port_arbiter: grant order, flush
// handling in ADDR/WAIT, and asynchronous reset mid-transaction.
module tb_icache_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [31:0]  dmd_addr, pf_addr;
    logic         dmd_valid, pf_valid;
    logic         dmd_ready, pf_ready;
    logic [127:0] dmd_data, pf_data;
    logic         dmd_data_valid, pf_data_valid;
    logic         dmd_data_ready, pf_data_ready;
    logic [31:0]  addr;
    logic         addr_valid, addr_ready;
    logic [127:0] data;
    logic         data_valid, data_ready;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;

    logic [127:0] line_a = {4{32'hA5A5_A5A5}};
    logic [127:0] line_b = {4{32'h3C3C_1234}};

    always #5 clk = ~clk;

    icache_port_arbiter #(.XLEN(32), .LINE_W(128), .STARVE_LIM(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .dmd_addr_i(dmd_addr), .dmd_valid_i(dmd_valid), .dmd_ready_o(dmd_ready),
        .pf_addr_i(pf_addr), .pf_valid_i(pf_valid), .pf_ready_o(pf_ready),
        .dmd_data_o(dmd_data), .dmd_data_valid_o(dmd_data_valid), .dmd_data_ready_i(dmd_data_ready),
        .pf_data_o(pf_data), .pf_data_valid_o(pf_data_valid), .pf_data_ready_i(pf_data_ready),
        .addr_o(addr), .addr_valid_o(addr_valid), .addr_ready_i(addr_ready),
        .data_i(data), .data_valid_i(data_valid), .data_ready_o(data_ready),
        .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Runs a plain demand transaction with the cache responding immediately.
    task automatic dmd_txn(input logic [31:0] a, input logic [127:0] line, input string tag);
        dmd_valid = 1'b1; dmd_addr = a; addr_ready = 1'b1; dmd_data_ready = 1'b1;
        settle();
        chk({tag, "_grant"}, dmd_ready, 1'b1);
        chk({tag, "_pfrdy"}, pf_ready, 1'b0);
        tick();
        dmd_valid = 1'b0;
        settle();
        chk({tag, "_avld"}, addr_valid, 1'b1);
        chk({tag, "_addr"}, addr, a);
        tick();
        data = line; data_valid = 1'b1;
        settle();
        chk({tag, "_drdy"}, data_ready, 1'b1);
        chk({tag, "_dvld"}, dmd_data_valid, 1'b1);
        chk({tag, "_pfvld"}, pf_data_valid, 1'b0);
        chk({tag, "_data"}, dmd_data, line);
        tick();
        data_valid = 1'b0;
        settle();
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        dmd_addr = '0; pf_addr = '0; dmd_valid = 1'b0; pf_valid = 1'b0;
        dmd_data_ready = 1'b0; pf_data_ready = 1'b0;
        addr_ready = 1'b0; data = '0; data_valid = 1'b0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_avld", addr_valid, 1'b0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_drdy", data_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Demand only, cache ready at once
        dmd_txn(32'h100, line_a, "d1");

        // Both requesters valid continuously: D D D P D D D P
        dmd_addr = 32'h1000; pf_addr = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            logic exp_pf;
            exp_pf = ((i % 4) == 3);
            dmd_valid = 1'b1; pf_valid = 1'b1; addr_ready = 1'b1;
            dmd_data_ready = 1'b1; pf_data_ready = 1'b1;
            settle();
            chk("go_cnt", 128'(dut.starve_cnt), 128'(i % 4));
            chk("go_dmd_rdy", dmd_ready, !exp_pf);
            chk("go_pf_rdy", pf_ready, exp_pf);
            tick();
            settle();
            chk("go_addr", addr, exp_pf ? 32'h2000 : 32'h1000);
            if (exp_pf) chk("go_cnt_clr", 128'(dut.starve_cnt), 128'(0));
            tick();
            data = line_b; data_valid = 1'b1;
            settle();
            chk("go_dvld_d", dmd_data_valid, !exp_pf);
            chk("go_dvld_p", pf_data_valid, exp_pf);
            tick();
            data_valid = 1'b0;
        end
        dmd_valid = 1'b0; pf_valid = 1'b0;
        dmd_data_ready = 1'b0; pf_data_ready = 1'b0;
        settle();
        chk("go_end_idle", busy, 1'b0);

        // Flush in ADDR with address held off two cycles
        dmd_valid = 1'b1; pf_valid = 1'b1; dmd_addr = 32'h300; addr_ready = 1'b0;
        settle();
        chk("fa_grant", dmd_ready, 1'b1);
        tick();
        dmd_valid = 1'b0; pf_valid = 1'b0;
        settle();
        chk("fa_cnt_pre", 128'(dut.starve_cnt), 128'(1));
        flush = 1'b1;
        settle();
        chk("fa_addr1", addr, 32'h300);
        chk("fa_avld1", addr_valid, 1'b1);
        chk("fa_nogrant", dmd_ready, 1'b0);
        tick();
        flush = 1'b0;
        settle();
        chk("fa_cnt_clr", 128'(dut.starve_cnt), 128'(0));
        chk("fa_addr2", addr, 32'h300);
        chk("fa_avld2", addr_valid, 1'b1);
        tick();
        addr_ready = 1'b1;
        settle();
        chk("fa_avld3", addr_valid, 1'b1);
        tick();
        addr_ready = 1'b0; dmd_data_ready = 1'b0;
        settle();
        chk("fa_disc_drdy", data_ready, 1'b1);
        chk("fa_disc_busy", busy, 1'b1);
        tick();
        dmd_data_ready = 1'b1; data = line_a; data_valid = 1'b1;
        settle();
        chk("fa_line_drdy", data_ready, 1'b1);
        chk("fa_line_dvld", dmd_data_valid, 1'b0);
        chk("fa_line_pvld", pf_data_valid, 1'b0);
        tick();
        data_valid = 1'b0;
        settle();
        chk("fa_busy_fall", busy, 1'b0);

        // Flush in WAIT, line three cycles later, then a normal request
        dmd_valid = 1'b1; dmd_addr = 32'h400; addr_ready = 1'b1;
        tick();
        dmd_valid = 1'b0;
        tick();
        flush = 1'b1; dmd_data_ready = 1'b0;
        settle();
        chk("fw_drdy", data_ready, 1'b1);
        chk("fw_dvld", dmd_data_valid, 1'b0);
        tick();
        flush = 1'b0;
        settle();
        chk("fw_disc_busy", busy, 1'b1);
        chk("fw_disc_drdy", data_ready, 1'b1);
        tick();
        tick();
        data = line_b; data_valid = 1'b1; dmd_data_ready = 1'b1;
        settle();
        chk("fw_drop_dvld", dmd_data_valid, 1'b0);
        chk("fw_drop_drdy", data_ready, 1'b1);
        tick();
        data_valid = 1'b0;
        settle();
        chk("fw_idle", busy, 1'b0);
        dmd_txn(32'h200, line_a, "fw_next");

        // Flush coincident with the returning line
        dmd_valid = 1'b1; dmd_addr = 32'h500; addr_ready = 1'b1;
        tick();
        dmd_valid = 1'b0;
        tick();
        flush = 1'b1; data = line_b; data_valid = 1'b1; dmd_data_ready = 1'b0;
        settle();
        chk("fc_drdy", data_ready, 1'b1);
        chk("fc_dvld", dmd_data_valid, 1'b0);
        tick();
        flush = 1'b0; data_valid = 1'b0;
        settle();
        chk("fc_idle", busy, 1'b0);

        // Reset asserted in WAIT, demand still requesting
        dmd_valid = 1'b1; dmd_addr = 32'h600; addr_ready = 1'b1; dmd_data_ready = 1'b1;
        tick();
        tick();
        settle();
        chk("rw_in_wait", busy, 1'b1);
        rst_n = 1'b0;
        settle();
        chk("rw_busy", busy, 1'b0);
        chk("rw_avld", addr_valid, 1'b0);
        chk("rw_addr", addr, 32'h0);
        chk("rw_drdy", data_ready, 1'b0);
        chk("rw_dmd_rdy", dmd_ready, 1'b0);
        chk("rw_pf_rdy", pf_ready, 1'b0);
        chk("rw_dvld", dmd_data_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        dmd_valid = 1'b0;
        tick();
        dmd_txn(32'h700, line_b, "rw_next");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
